id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameters: REG_DATA_WIDTH, 32, datapath width; REG_ADDR_WIDTH, 5, register index width; FUNCT3_WIDTH, 3, funct3 width.
REQ-002 SHALL have ports (name direction width meaning):
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- id_valid  in  1  decode stage holds a valid instruction
- id_pc  in  32  instruction PC
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  5  each  source/destination indices
- id_rs1_data, id_rs2_data  in  32  each  register-file read data
- id_imm  in  32  sign-extended immediate
- id_funct3  in  3  funct3 field
- id_inst30  in  1  instruction bit 30
- id_aluop  in  2  00 addr-add, 01 branch/jalr, 10 R, 11 I-op
- id_alusrc1  in  1  0 = rs1, 1 = PC
- id_alusrc2  in  1  0 = rs2, 1 = imm
- id_memread, id_memwrite, id_regwrite  in  1  each  control bits
- ex_flush  in  1  taken branch/jump redirect from EX
- mem_regwrite  in  1, mem_rd_addr  in  5, mem_result  in  32  EX/MEM forwarding source
- wb_regwrite  in  1, wb_rd_addr  in  5, wb_data  in  32  MEM/WB forwarding source
- id_stall  out  1  hold PC and IF/ID register this cycle
- ex_valid  out  1  EX holds a valid instruction
- ex_pc  out  32; alu_op1, alu_op2  out  32  ALU operands
- ex_rs2_fwd  out  32  forwarded store data
- ex_funct3  out  3; ex_inst30  out  1; ex_aluop  out  2
- ex_rd_addr  out  5; ex_memread, ex_memwrite, ex_regwrite  out  1 each

Function
REQ-003 SHALL register all id_* fields into EX state on each rising edge; ex_* outputs driven from that state; one-cycle latency ID->EX.
REQ-004 SHALL assert id_stall combinationally when ex_valid & ex_memread & ex_rd_addr!=0 & id_valid & (id_rs1_addr==ex_rd_addr | id_rs2_addr==ex_rd_addr), and ex_flush=0.
REQ-005 SHALL, on an edge with id_stall=1, load a bubble: ex_valid=0, ex_memread=ex_memwrite=ex_regwrite=0; data fields don't-care.
REQ-006 SHALL, on an edge with ex_flush=1, load a bubble as in REQ-005; flush overrides stall; id_stall=0 while ex_flush=1.
REQ-007 SHALL also load a bubble when id_valid=0.
REQ-008 SHALL, at capture, replace id_rsN_data with wb_data when wb_regwrite & wb_rd_addr==id_rsN_addr & id_rsN_addr!=0 (write-through of same-cycle writeback), N=1,2.
REQ-009 SHALL form fwd_rsN combinationally from registered rsN address/data: mem_result if mem_regwrite & mem_rd_addr==rsN & rsN!=0; else wb_data if wb_regwrite & wb_rd_addr==rsN & rsN!=0; else registered data. EX/MEM wins over MEM/WB.
REQ-010 SHALL never forward to index 0; x0 operand is always the registered value (zero from regfile).
REQ-011 SHALL drive alu_op1 = id_alusrc1-registered ? ex_pc : fwd_rs1; alu_op2 = alusrc2-registered ? ex_imm : fwd_rs2; ex_rs2_fwd = fwd_rs2 regardless of alusrc2.
REQ-012 SHALL pass funct3, inst30, aluop, rd_addr unchanged (bit-exact, no sign/width changes).
REQ-013 SHALL keep ex_rd_addr and controls of a bubble such that downstream forwarding never matches (ex_regwrite=0).

Reset
REQ-014 SHALL, on rising edge with rst=1, clear all EX state: ex_valid=0, all control 0, ex_pc/ex_imm/operand regs/rd/funct3/aluop/inst30=0; rst overrides flush, stall, and capture.
REQ-015 SHALL drive id_stall=0 in the cycle after reset (ex_valid=0); reset mid-stall cancels the stall.

Verification
REQ-016 Back-to-back ALU: add x3 (mem_regwrite=1, mem_rd=3, mem_result=0x10) while EX holds rs1=3 -> alu_op1=0x10.
REQ-017 Dual match: mem_rd=5 result 0xAA, wb_rd=5 data 0xBB, EX rs2=5, alusrc2=0 -> alu_op2=0xAA, ex_rs2_fwd=0xAA.
REQ-018 Load-use: EX lw x7 (memread=1), ID add rs1=7 -> id_stall=1, next cycle ex_valid=0, ex_regwrite=0, then add captured with stall=0.
REQ-019 Flush during load-use: same as REQ-018 plus ex_flush=1 -> id_stall=0, next ex_valid=0.
REQ-020 x0 and write-through: wb_rd=0 data 0xFF with rs1=0 -> alu_op1=0; wb_rd=4 data 0x12 at capture with id_rs1=4, id_rs1_data=0 -> after edge alu_op1=0x12 with no forwarding active.
REQ-021 Reset mid-operation: valid lw in EX, rst=1 one edge -> ex_valid=0, ex_memread=0, id_stall=0, alu_op1=alu_op2=0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage of an in-order RISC-V integer pipeline.
// Captures decoded fields into EX state. Detects the load-use hazard and
// inserts a bubble for it. Forwards EX/MEM and MEM/WB results into the
// ALU operands and the store data.
//
// Ports:
//   clk, rst        - clock; synchronous active-high reset
//   id_*            - decoded instruction, register data and control from ID
//   ex_flush        - redirect from EX (taken branch/jump); squashes the ID slot
//   mem_*           - EX/MEM forwarding source (regwrite, rd, result)
//   wb_*            - MEM/WB forwarding source (regwrite, rd, data)
//   id_stall        - hold PC and IF/ID this cycle (load-use hazard)
//   ex_*            - registered EX fields and controls
//   alu_op1/alu_op2 - ALU operands after forwarding and source selection
//   ex_rs2_fwd      - forwarded rs2 value, used as store data
module id_ex_stage #(
   parameter int unsigned REG_DATA_WIDTH = 32,
   parameter int unsigned REG_ADDR_WIDTH = 5,
   parameter int unsigned FUNCT3_WIDTH   = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      id_valid,
   input  logic [REG_DATA_WIDTH-1:0] id_pc,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
   input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr,
   input  logic [REG_DATA_WIDTH-1:0] id_rs1_data,
   input  logic [REG_DATA_WIDTH-1:0] id_rs2_data,
   input  logic [REG_DATA_WIDTH-1:0] id_imm,
   input  logic [FUNCT3_WIDTH-1:0]   id_funct3,
   input  logic                      id_inst30,
   input  logic [1:0]                id_aluop,
   input  logic                      id_alusrc1,
   input  logic                      id_alusrc2,
   input  logic                      id_memread,
   input  logic                      id_memwrite,
   input  logic                      id_regwrite,
   input  logic                      ex_flush,
   input  logic                      mem_regwrite,
   input  logic [REG_ADDR_WIDTH-1:0] mem_rd_addr,
   input  logic [REG_DATA_WIDTH-1:0] mem_result,
   input  logic                      wb_regwrite,
   input  logic [REG_ADDR_WIDTH-1:0] wb_rd_addr,
   input  logic [REG_DATA_WIDTH-1:0] wb_data,
   output logic                      id_stall,
   output logic                      ex_valid,
   output logic [REG_DATA_WIDTH-1:0] ex_pc,
   output logic [REG_DATA_WIDTH-1:0] alu_op1,
   output logic [REG_DATA_WIDTH-1:0] alu_op2,
   output logic [REG_DATA_WIDTH-1:0] ex_rs2_fwd,
   output logic [FUNCT3_WIDTH-1:0]   ex_funct3,
   output logic                      ex_inst30,
   output logic [1:0]                ex_aluop,
   output logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
   output logic                      ex_memread,
   output logic                      ex_memwrite,
   output logic                      ex_regwrite
);

   // EX state not exposed directly on ports
   logic [REG_ADDR_WIDTH-1:0] ex_rs1_addr;
   logic [REG_ADDR_WIDTH-1:0] ex_rs2_addr;
   logic [REG_DATA_WIDTH-1:0] ex_rs1_data;
   logic [REG_DATA_WIDTH-1:0] ex_rs2_data;
   logic [REG_DATA_WIDTH-1:0] ex_imm;
   logic                      ex_alusrc1;
   logic                      ex_alusrc2;

   logic                      rs1_hit;
   logic                      rs2_hit;
   logic                      capture;
   logic [REG_DATA_WIDTH-1:0] rs1_wt;
   logic [REG_DATA_WIDTH-1:0] rs2_wt;
   logic [REG_DATA_WIDTH-1:0] fwd_rs1;
   logic [REG_DATA_WIDTH-1:0] fwd_rs2;

   // Load-use hazard: the load in EX writes a register the ID instruction reads.
   // A flush squashes the ID instruction, so no stall is needed then.
   always_comb begin
      rs1_hit  = (id_rs1_addr == ex_rd_addr);
      rs2_hit  = (id_rs2_addr == ex_rd_addr);
      id_stall = ex_valid && ex_memread && (ex_rd_addr != '0) && id_valid &&
                 (rs1_hit || rs2_hit) && !ex_flush;
      capture  = id_valid && !ex_flush && !id_stall;
   end

   // The register file is read in the same cycle the writeback lands,
   // so pass the writeback value through on an index match.
   always_comb begin
      rs1_wt = id_rs1_data;
      rs2_wt = id_rs2_data;
      if (wb_regwrite && (wb_rd_addr == id_rs1_addr) && (id_rs1_addr != '0))
         rs1_wt = wb_data;
      if (wb_regwrite && (wb_rd_addr == id_rs2_addr) && (id_rs2_addr != '0))
         rs2_wt = wb_data;
   end

   // EX state register. Data fields are loaded even for a bubble because
   // they are don't-care once ex_valid and the controls are cleared.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid    <= 1'b0;
         ex_memread  <= 1'b0;
         ex_memwrite <= 1'b0;
         ex_regwrite <= 1'b0;
         ex_pc       <= '0;
         ex_rs1_addr <= '0;
         ex_rs2_addr <= '0;
         ex_rs1_data <= '0;
         ex_rs2_data <= '0;
         ex_imm      <= '0;
         ex_rd_addr  <= '0;
         ex_funct3   <= '0;
         ex_inst30   <= 1'b0;
         ex_aluop    <= '0;
         ex_alusrc1  <= 1'b0;
         ex_alusrc2  <= 1'b0;
      end else begin
         ex_valid    <= capture;
         ex_memread  <= capture && id_memread;
         ex_memwrite <= capture && id_memwrite;
         ex_regwrite <= capture && id_regwrite;
         ex_pc       <= id_pc;
         ex_rs1_addr <= id_rs1_addr;
         ex_rs2_addr <= id_rs2_addr;
         ex_rs1_data <= rs1_wt;
         ex_rs2_data <= rs2_wt;
         ex_imm      <= id_imm;
         ex_rd_addr  <= id_rd_addr;
         ex_funct3   <= id_funct3;
         ex_inst30   <= id_inst30;
         ex_aluop    <= id_aluop;
         ex_alusrc1  <= id_alusrc1;
         ex_alusrc2  <= id_alusrc2;
      end
   end

   // Operand forwarding: the younger EX/MEM result wins over MEM/WB; x0 never forwards.
   always_comb begin
      fwd_rs1 = ex_rs1_data;
      if (mem_regwrite && (mem_rd_addr == ex_rs1_addr) && (ex_rs1_addr != '0))
         fwd_rs1 = mem_result;
      else if (wb_regwrite && (wb_rd_addr == ex_rs1_addr) && (ex_rs1_addr != '0))
         fwd_rs1 = wb_data;

      fwd_rs2 = ex_rs2_data;
      if (mem_regwrite && (mem_rd_addr == ex_rs2_addr) && (ex_rs2_addr != '0))
         fwd_rs2 = mem_result;
      else if (wb_regwrite && (wb_rd_addr == ex_rs2_addr) && (ex_rs2_addr != '0))
         fwd_rs2 = wb_data;
   end

   // ALU source selection; store data always takes the forwarded rs2
   always_comb begin
      alu_op1    = ex_alusrc1 ? ex_pc  : fwd_rs1;
      alu_op2    = ex_alusrc2 ? ex_imm : fwd_rs2;
      ex_rs2_fwd = fwd_rs2;
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: reference model of the EX state,
// a scoreboard queue of expected captures, and combinational checks of
// stall/operands in the middle of each cycle.
module tb_id_ex_stage;

   logic        clk;
   logic        rst;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
   logic [31:0] id_rs1_data, id_rs2_data, id_imm;
   logic [2:0]  id_funct3;
   logic        id_inst30;
   logic [1:0]  id_aluop;
   logic        id_alusrc1, id_alusrc2;
   logic        id_memread, id_memwrite, id_regwrite;
   logic        ex_flush;
   logic        mem_regwrite;
   logic [4:0]  mem_rd_addr;
   logic [31:0] mem_result;
   logic        wb_regwrite;
   logic [4:0]  wb_rd_addr;
   logic [31:0] wb_data;
   logic        id_stall;
   logic        ex_valid;
   logic [31:0] ex_pc, alu_op1, alu_op2, ex_rs2_fwd;
   logic [2:0]  ex_funct3;
   logic        ex_inst30;
   logic [1:0]  ex_aluop;
   logic [4:0]  ex_rd_addr;
   logic        ex_memread, ex_memwrite, ex_regwrite;

   id_ex_stage dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_funct3(id_funct3), .id_inst30(id_inst30), .id_aluop(id_aluop),
      .id_alusrc1(id_alusrc1), .id_alusrc2(id_alusrc2),
      .id_memread(id_memread), .id_memwrite(id_memwrite), .id_regwrite(id_regwrite),
      .ex_flush(ex_flush),
      .mem_regwrite(mem_regwrite), .mem_rd_addr(mem_rd_addr), .mem_result(mem_result),
      .wb_regwrite(wb_regwrite), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
      .id_stall(id_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
      .alu_op1(alu_op1), .alu_op2(alu_op2), .ex_rs2_fwd(ex_rs2_fwd),
      .ex_funct3(ex_funct3), .ex_inst30(ex_inst30), .ex_aluop(ex_aluop),
      .ex_rd_addr(ex_rd_addr), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
      .ex_regwrite(ex_regwrite)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        valid;
      logic        mr;
      logic        mw;
      logic        rw;
      logic        known;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic        i30;
      logic [1:0]  aluop;
      logic [31:0] pc;
   } exp_t;

   exp_t exp_q[$];

   int n_cmp = 0;
   int n_err = 0;

   // model of EX state; m_known=0 after a bubble (data fields don't-care)
   logic        m_valid, m_mr, m_mw, m_rw, m_known, m_src1, m_src2, m_i30;
   logic [4:0]  m_rs1, m_rs2, m_rd;
   logic [31:0] m_pc, m_imm, m_d1, m_d2;
   logic [2:0]  m_f3;
   logic [1:0]  m_aluop;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_fwd(input logic [4:0] a, input logic [31:0] d);
      if (mem_regwrite && mem_rd_addr == a && a != 5'd0) return mem_result;
      if (wb_regwrite && wb_rd_addr == a && a != 5'd0) return wb_data;
      return d;
   endfunction

   function automatic logic [31:0] model_wt(input logic [4:0] a, input logic [31:0] d);
      if (wb_regwrite && wb_rd_addr == a && a != 5'd0) return wb_data;
      return d;
   endfunction

   task automatic clear_inputs();
      rst = 1'b0; id_valid = 1'b0; id_pc = '0;
      id_rs1_addr = '0; id_rs2_addr = '0; id_rd_addr = '0;
      id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
      id_funct3 = '0; id_inst30 = 1'b0; id_aluop = '0;
      id_alusrc1 = 1'b0; id_alusrc2 = 1'b0;
      id_memread = 1'b0; id_memwrite = 1'b0; id_regwrite = 1'b0;
      ex_flush = 1'b0;
      mem_regwrite = 1'b0; mem_rd_addr = '0; mem_result = '0;
      wb_regwrite = 1'b0; wb_rd_addr = '0; wb_data = '0;
   endtask

   // Check combinational outputs mid-cycle, predict the capture, then clock and compare.
   task automatic tick();
      logic stall_e, cap;
      exp_t e, g;
      #2;
      stall_e = m_valid && m_mr && (m_rd != 5'd0) && id_valid &&
                ((id_rs1_addr == m_rd) || (id_rs2_addr == m_rd)) && !ex_flush;
      check("id_stall", 32'(id_stall), 32'(stall_e));
      if (m_known) begin
         check("alu_op1", alu_op1, m_src1 ? m_pc : model_fwd(m_rs1, m_d1));
         check("alu_op2", alu_op2, m_src2 ? m_imm : model_fwd(m_rs2, m_d2));
         check("ex_rs2_fwd", ex_rs2_fwd, model_fwd(m_rs2, m_d2));
      end
      if (rst) begin
         m_valid = 0; m_mr = 0; m_mw = 0; m_rw = 0; m_known = 1;
         m_src1 = 0; m_src2 = 0; m_i30 = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
         m_pc = 0; m_imm = 0; m_d1 = 0; m_d2 = 0; m_f3 = 0; m_aluop = 0;
      end else begin
         cap     = id_valid && !ex_flush && !stall_e;
         m_valid = cap;
         m_mr    = cap && id_memread;
         m_mw    = cap && id_memwrite;
         m_rw    = cap && id_regwrite;
         m_known = cap;
         m_src1  = id_alusrc1; m_src2 = id_alusrc2; m_i30 = id_inst30;
         m_rs1   = id_rs1_addr; m_rs2 = id_rs2_addr; m_rd = id_rd_addr;
         m_pc    = id_pc; m_imm = id_imm; m_f3 = id_funct3; m_aluop = id_aluop;
         m_d1    = model_wt(id_rs1_addr, id_rs1_data);
         m_d2    = model_wt(id_rs2_addr, id_rs2_data);
      end
      e = '{valid: m_valid, mr: m_mr, mw: m_mw, rw: m_rw, known: m_known,
            rd: m_rd, f3: m_f3, i30: m_i30, aluop: m_aluop, pc: m_pc};
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         g = exp_q.pop_front();
         check("ex_valid", 32'(ex_valid), 32'(g.valid));
         check("ex_memread", 32'(ex_memread), 32'(g.mr));
         check("ex_memwrite", 32'(ex_memwrite), 32'(g.mw));
         check("ex_regwrite", 32'(ex_regwrite), 32'(g.rw));
         if (g.known) begin
            check("ex_rd_addr", 32'(ex_rd_addr), 32'(g.rd));
            check("ex_funct3", 32'(ex_funct3), 32'(g.f3));
            check("ex_inst30", 32'(ex_inst30), 32'(g.i30));
            check("ex_aluop", 32'(ex_aluop), 32'(g.aluop));
            check("ex_pc", ex_pc, g.pc);
         end
      end
   endtask

   task automatic set_lw_x7();
      clear_inputs();
      id_valid = 1; id_pc = 32'h100; id_rs1_addr = 5'd2; id_rs1_data = 32'h1000;
      id_imm = 32'h8; id_rd_addr = 5'd7; id_funct3 = 3'b010; id_aluop = 2'b00;
      id_alusrc2 = 1; id_memread = 1; id_regwrite = 1;
   endtask

   task automatic set_add_rs1_7();
      clear_inputs();
      id_valid = 1; id_pc = 32'h104; id_rs1_addr = 5'd7; id_rs2_addr = 5'd1;
      id_rs1_data = 32'h11; id_rs2_data = 32'h22; id_rd_addr = 5'd9;
      id_aluop = 2'b10; id_regwrite = 1;
   endtask

   initial begin
      m_valid = 0; m_mr = 0; m_mw = 0; m_rw = 0; m_known = 0;
      m_src1 = 0; m_src2 = 0; m_i30 = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
      m_pc = 0; m_imm = 0; m_d1 = 0; m_d2 = 0; m_f3 = 0; m_aluop = 0;
      clear_inputs();
      rst = 1;
      @(posedge clk); #1;
      tick();
      rst = 0;
      check("reset_alu_op1", alu_op1, 32'h0);
      check("reset_stall", 32'(id_stall), 32'h0);

      // back-to-back ALU forwarding from EX/MEM
      clear_inputs();
      id_valid = 1; id_pc = 32'h200; id_rs1_addr = 5'd3; id_rs2_addr = 5'd4;
      id_rs1_data = 32'h5; id_rs2_data = 32'h6; id_rd_addr = 5'd8;
      id_funct3 = 3'b111; id_inst30 = 1; id_aluop = 2'b10; id_regwrite = 1;
      tick();
      clear_inputs();
      mem_regwrite = 1; mem_rd_addr = 5'd3; mem_result = 32'h10;
      #1 check("b2b_alu_op1", alu_op1, 32'h10);
      tick();

      // dual match: EX/MEM wins over MEM/WB
      clear_inputs();
      id_valid = 1; id_pc = 32'h300; id_rs1_addr = 5'd1; id_rs2_addr = 5'd5;
      id_rs1_data = 32'h1; id_rs2_data = 32'h2; id_rd_addr = 5'd6; id_regwrite = 1;
      tick();
      clear_inputs();
      mem_regwrite = 1; mem_rd_addr = 5'd5; mem_result = 32'hAA;
      wb_regwrite = 1; wb_rd_addr = 5'd5; wb_data = 32'hBB;
      #1 check("dual_alu_op2", alu_op2, 32'hAA);
      check("dual_rs2_fwd", ex_rs2_fwd, 32'hAA);
      tick();

      // load-use: stall, bubble, then capture
      set_lw_x7();
      tick();
      set_add_rs1_7();
      #1 check("loaduse_stall", 32'(id_stall), 32'h1);
      tick();
      check("loaduse_bubble_valid", 32'(ex_valid), 32'h0);
      check("loaduse_bubble_rw", 32'(ex_regwrite), 32'h0);
      set_add_rs1_7();
      tick();
      check("loaduse_capture", 32'(ex_valid), 32'h1);

      // flush during load-use
      set_lw_x7();
      tick();
      set_add_rs1_7();
      ex_flush = 1;
      #1 check("flush_stall", 32'(id_stall), 32'h0);
      tick();
      check("flush_bubble", 32'(ex_valid), 32'h0);

      // x0 never forwards; same-cycle writeback passes through at capture
      clear_inputs();
      id_valid = 1; id_pc = 32'h400; id_rd_addr = 5'd1; id_regwrite = 1;
      tick();
      clear_inputs();
      wb_regwrite = 1; wb_rd_addr = 5'd0; wb_data = 32'hFF;
      #1 check("x0_alu_op1", alu_op1, 32'h0);
      id_valid = 1; id_pc = 32'h404; id_rs1_addr = 5'd4; id_rs1_data = 32'h0;
      id_rd_addr = 5'd2; id_regwrite = 1;
      wb_rd_addr = 5'd4; wb_data = 32'h12;
      tick();
      clear_inputs();
      #1 check("wt_alu_op1", alu_op1, 32'h12);
      tick();

      // reset while a load sits in EX
      set_lw_x7();
      tick();
      set_add_rs1_7();
      rst = 1;
      tick();
      clear_inputs();
      set_add_rs1_7();
      #1 check("rst_ex_valid", 32'(ex_valid), 32'h0);
      check("rst_memread", 32'(ex_memread), 32'h0);
      check("rst_stall", 32'(id_stall), 32'h0);
      check("rst_alu_op1", alu_op1, 32'h0);
      check("rst_alu_op2", alu_op2, 32'h0);
      tick();

      // randomized traffic over a small register range to provoke hazards
      for (int i = 0; i < 300; i++) begin
         clear_inputs();
         rst          = ($urandom_range(0, 31) == 0);
         id_valid     = ($urandom_range(0, 3) != 0);
         id_pc        = $urandom;
         id_rs1_addr  = 5'($urandom_range(0, 7));
         id_rs2_addr  = 5'($urandom_range(0, 7));
         id_rd_addr   = 5'($urandom_range(0, 7));
         id_rs1_data  = (id_rs1_addr == 5'd0) ? 32'h0 : $urandom;
         id_rs2_data  = (id_rs2_addr == 5'd0) ? 32'h0 : $urandom;
         id_imm       = $urandom;
         id_funct3    = 3'($urandom);
         id_inst30    = 1'($urandom);
         id_aluop     = 2'($urandom);
         id_alusrc1   = 1'($urandom);
         id_alusrc2   = 1'($urandom);
         id_memread   = ($urandom_range(0, 2) == 0);
         id_memwrite  = 1'($urandom);
         id_regwrite  = 1'($urandom);
         ex_flush     = ($urandom_range(0, 7) == 0);
         mem_regwrite = 1'($urandom);
         mem_rd_addr  = 5'($urandom_range(0, 7));
         mem_result   = $urandom;
         wb_regwrite  = 1'($urandom);
         wb_rd_addr   = 5'($urandom_range(0, 7));
         wb_data      = $urandom;
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
